seq_subtractor: RTL and testbench
=================================

# seq_subtractor

Multi-cycle, handshaked subtractor computing data1_i − data2_i one CHUNK_WIDTH slice per clock, LSB chunk first, with borrow propagated between slices. It is the inverse-direction companion to the primitives adder and lives beside it in the primitives library. It is used where a full-width combinational borrow chain would miss timing and throughput of one result per few cycles is acceptable.

## Interface
- ARCHITECTURE, "BEHAVIORAL": BEHAVIORAL, VIRTEX5 or VIRTEX6. All values currently build the behavioural datapath; the others are reserved for primitive-based variants.
- DATA_WIDTH_1, 8: width of the minuend data1_i, ≥1.
- DATA_WIDTH_2, 8: width of the subtrahend data2_i, ≥1.
- CHUNK_WIDTH, 4: bits processed per cycle, ≥1.
- Derived: W = max(DATA_WIDTH_1, DATA_WIDTH_2); N = ceil(W / CHUNK_WIDTH).
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data1_i  in  DATA_WIDTH_1  minuend, unsigned.
- data2_i  in  DATA_WIDTH_2  subtrahend, unsigned.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept operands.
- data_o  out  W+1  result: {borrow, difference}, i.e. the (W+1)-bit two's-complement value of a − b.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts the result.

## Operation
- Operands are zero-extended to N·CHUNK_WIDTH bits.
- Result low W bits = (a − b) mod 2^W. data_o[W] = borrow out of the top chunk, which equals 1 iff a < b.
- FSM states: IDLE, BUSY, DONE.
- IDLE: ready_o = 1 (forced to 0 while rst_i is high). On valid_i & ready_o:
  - latch both operands;
  - clear the borrow register and chunk counter;
  - go to BUSY.
- BUSY: each cycle, subtract chunk[count] with borrow-in from the borrow register, write the difference slice into the result register, store borrow-out, increment count. After the chunk with count = N−1, go to DONE.
- DONE: valid_o = 1 and data_o is stable. On ready_i, go to IDLE.
- ready_o is 0 in BUSY and DONE. valid_i in those states is ignored; operands are not captured.
- Input operands may change freely after acceptance.
- N = 1 (CHUNK_WIDTH ≥ W): exactly one BUSY cycle.
- Reset, including mid-BUSY or mid-DONE: the next state is IDLE and the in-flight operation is discarded with no result emitted.
  - Reset values: valid_o = 0, data_o = 0, borrow = 0, count = 0. ready_o = 0 while rst_i is high, and 1 in the first cycle after it drops.

## Timing
- Accept on edge E0. Chunks are computed on edges E1..EN. valid_o is high from just after EN.
- Latency is N+1 edges from accept to valid_o.
- DONE→IDLE occurs on the edge where valid_o & ready_i. ready_o is high the following cycle.
- Minimum period per operation is N+2 cycles with ready_i held high.
- No combinational path from valid_i or ready_i to ready_o or valid_o. All outputs except ready_o (state decode plus rst_i) come from registers.

## Structure
- Shared primitives package holds:
  - FSM state encodings IDLE, BUSY, DONE as localparams;
  - max and ceil-div constant functions used for W and N.
- One combinational sub-module, sub_chunk: a CHUNK_WIDTH-bit subtract with borrow_in and borrow_out, instantiated once. The operand slice is selected by the counter.
- Counter width is clog2(N), minimum 1 bit.

## Test plan
- DW1 = DW2 = 8, CW = 4: 0xA5 − 0x3C → data_o = 0x069, borrow 0. valid_o is first high 3 edges after accept.
- Same configuration, 0x3C − 0xA5 → data_o = 0x197 (low byte 0x97, borrow 1).
- Same configuration, inter-chunk borrow: 0x10 − 0x01 → 0x00F. 0x00 − 0x00 → 0x000, borrow 0.
- Backpressure: hold ready_i = 0 for 5 cycles in DONE and pulse valid_i with new operands. Required: valid_o and data_o stay stable, ready_o stays 0, and the new operands are not captured. Releasing ready_i gives ready_o = 1 on the next cycle.
- Reset: assert rst_i one cycle after accept. Required: next cycle valid_o = 0 and data_o = 0; ready_o = 1 the cycle after rst_i drops; no result is emitted for the aborted operation.
- DW1 = 6, DW2 = 3, CW = 4 (W = 6, N = 2): 0x3F − 0x7 → 0x38; 0x00 − 0x7 → 0x79. With CW = 8 (N = 1), the same results appear 2 edges after accept.

Source files
------------

// File: rtl/seq_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// seq_subtractor_pkg
//   Shared primitives package for the sequential subtractor.
//   Holds the control FSM state encoding and the constant functions used to
//   size the datapath (operand width W and chunk count N).
// ---------------------------------------------------------------------------
package seq_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/seq_subtractor_sub_chunk.sv
// ---------------------------------------------------------------------------
// sub_chunk
//   Combinational CHUNK_WIDTH-bit subtract with borrow: diff = a - b - borrow_in.
//   Ports:
//     a, b        CHUNK_WIDTH  minuend / subtrahend slice
//     borrow_in   1            borrow from the less-significant slice
//     diff        CHUNK_WIDTH  difference slice
//     borrow_out  1            borrow into the more-significant slice
// ---------------------------------------------------------------------------
module sub_chunk #(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   borrow_in,
  output logic [CHUNK_WIDTH-1:0] diff,
  output logic                   borrow_out
);

  // One extra bit on the left catches the wrap; it is set exactly when the
  // slice result went negative, i.e. a borrow is needed from above.
  always_comb begin
    {borrow_out, diff} = {1'b0, a} - {1'b0, b} - (CHUNK_WIDTH + 1)'(borrow_in);
  end

endmodule

// File: rtl/seq_subtractor.sv
// ---------------------------------------------------------------------------
// seq_subtractor
//   Multi-cycle handshaked subtractor: data_o = data1_i - data2_i computed one
//   CHUNK_WIDTH slice per clock, LSB slice first, borrow carried in a register.
//   Ports:
//     clk_i     clock, rising edge
//     rst_i     synchronous active-high reset
//     data1_i   DATA_WIDTH_1  unsigned minuend
//     data2_i   DATA_WIDTH_2  unsigned subtrahend
//     valid_i   operands valid
//     ready_o   block can accept operands (IDLE and not in reset)
//     data_o    W+1  {borrow, difference}, two's-complement a - b
//     valid_o   data_o valid (DONE)
//     ready_i   downstream accepts the result
// ---------------------------------------------------------------------------
module seq_subtractor
  import seq_subtractor_pkg::*;
#(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    DATA_WIDTH_1 = 8,
  parameter int    DATA_WIDTH_2 = 8,
  parameter int    CHUNK_WIDTH  = 4,
  localparam int   W            = max_int(DATA_WIDTH_1, DATA_WIDTH_2)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DATA_WIDTH_1-1:0] data1_i,
  input  logic [DATA_WIDTH_2-1:0] data2_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [W:0]              data_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int N     = ceil_div(W, CHUNK_WIDTH);
  localparam int PW    = N * CHUNK_WIDTH;           // padded operand width
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    a_q, b_q, res_q;
  logic             borrow_q;
  logic [CNT_W-1:0] count_q;

  logic                   accept;
  logic [CHUNK_WIDTH-1:0] a_slice, b_slice, diff;
  logic                   borrow_out;

  // ---------------------------------------------------------------- FSM ---
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: if (valid_i) begin
        accept  = 1'b1;
        state_d = BUSY;
      end
      BUSY: if (count_q == LAST) state_d = DONE;
      DONE: if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready_o is the only output with a path from rst_i: the block must not
  // advertise readiness while reset is being applied.
  assign ready_o = (state_q == IDLE) && !rst_i;
  assign valid_o = (state_q == DONE);
  assign data_o  = {borrow_q, res_q[W-1:0]};

  // ----------------------------------------------------------- datapath ---
  assign a_slice = a_q[int'(count_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
  assign b_slice = b_q[int'(count_q) * CHUNK_WIDTH +: CHUNK_WIDTH];

  if (ARCHITECTURE == "VIRTEX5" || ARCHITECTURE == "VIRTEX6") begin : g_prim
    // Reserved for a carry-chain primitive variant; behavioural slice for now.
    sub_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_sub_chunk (
      .a(a_slice), .b(b_slice), .borrow_in(borrow_q),
      .diff(diff), .borrow_out(borrow_out)
    );
  end else begin : g_behav
    sub_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_sub_chunk (
      .a(a_slice), .b(b_slice), .borrow_in(borrow_q),
      .diff(diff), .borrow_out(borrow_out)
    );
  end

  // NOTE: operand registers are deliberately not reset; they are only read
  // after being loaded on accept, so a reset would cost routing for nothing.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      a_q <= PW'(data1_i);   // zero-extend to whole chunks
      b_q <= PW'(data2_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
    end else if (accept) begin
      borrow_q <= 1'b0;
      count_q  <= '0;
    end else if (state_q == BUSY) begin
      res_q[int'(count_q) * CHUNK_WIDTH +: CHUNK_WIDTH] <= diff;
      borrow_q <= borrow_out;
      // Counter stays at LAST through DONE; accept clears it.
      if (count_q != LAST) count_q <= count_q + 1'b1;
    end
  end

  // Padding bits of the result exist only to keep slice writes uniform.
  if (PW > W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^res_q[PW-1:W];
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// ---------------------------------------------------------------------------
// tb_seq_subtractor
//   Directed bench for seq_subtractor. Three instances share clock and reset:
//     dut_a : DW1=8, DW2=8, CW=4 (N=2)
//     dut_b : DW1=6, DW2=3, CW=4 (N=2)
//     dut_c : DW1=6, DW2=3, CW=8 (N=1)
//   Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_seq_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut_a signals
  logic [7:0] a_d1 = '0, a_d2 = '0;
  logic       a_valid = 1'b0, a_rdy_in = 1'b0;
  logic       a_rdy_out, a_vo;
  logic [8:0] a_data;

  // dut_b / dut_c share operands and handshake inputs
  logic [5:0] bc_d1 = '0;
  logic [2:0] bc_d2 = '0;
  logic       bc_valid = 1'b0, bc_rdy_in = 1'b0;
  logic       b_rdy_out, b_vo, c_rdy_out, c_vo;
  logic [6:0] b_data, c_data;

  seq_subtractor #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH_1(8), .DATA_WIDTH_2(8),
                   .CHUNK_WIDTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .data1_i(a_d1), .data2_i(a_d2), .valid_i(a_valid),
    .ready_o(a_rdy_out), .data_o(a_data), .valid_o(a_vo), .ready_i(a_rdy_in));

  seq_subtractor #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH_1(6), .DATA_WIDTH_2(3),
                   .CHUNK_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .data1_i(bc_d1), .data2_i(bc_d2), .valid_i(bc_valid),
    .ready_o(b_rdy_out), .data_o(b_data), .valid_o(b_vo), .ready_i(bc_rdy_in));

  seq_subtractor #(.ARCHITECTURE("VIRTEX6"), .DATA_WIDTH_1(6), .DATA_WIDTH_2(3),
                   .CHUNK_WIDTH(8)) dut_c (
    .clk_i(clk), .rst_i(rst), .data1_i(bc_d1), .data2_i(bc_d2), .valid_i(bc_valid),
    .ready_o(c_rdy_out), .data_o(c_data), .valid_o(c_vo), .ready_i(bc_rdy_in));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation on dut_a, return the edge count (accept edge = 1) at
  // which valid_o is first seen; leaves the DUT sitting in DONE.
  task automatic start_a(input logic [7:0] d1, input logic [7:0] d2, output int edges);
    edges = 0;
    a_d1 = d1; a_d2 = d2; a_valid = 1'b1;
    while (edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        a_valid = 1'b0;
        a_d1 = ~d1; a_d2 = ~d2;   // operands may change after acceptance
      end
      if (a_vo) break;
    end
  endtask

  task automatic release_a(input string tag);
    a_rdy_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_rdy_in = 1'b0;
    check({tag, "_rdy_after"}, 32'(a_rdy_out), 32'd1);
    check({tag, "_vo_after"},  32'(a_vo),      32'd0);
  endtask

  task automatic op_a(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                      input logic [8:0] exp);
    int edges;
    start_a(d1, d2, edges);
    check({tag, "_lat"},  32'(edges),  32'd3);
    check({tag, "_data"}, 32'(a_data), 32'(exp));
    release_a(tag);
  endtask

  // Same operands into dut_b (N=2) and dut_c (N=1) at once.
  task automatic op_bc(input string tag, input logic [5:0] d1, input logic [2:0] d2,
                       input logic [6:0] exp);
    int edges, b_lat, c_lat;
    edges = 0; b_lat = 0; c_lat = 0;
    bc_d1 = d1; bc_d2 = d2; bc_valid = 1'b1;
    while (edges < 20 && (b_lat == 0 || c_lat == 0)) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        bc_valid = 1'b0;
        bc_d1 = ~d1; bc_d2 = ~d2;
      end
      if (b_vo && b_lat == 0) begin
        b_lat = edges;
        check({tag, "_b_data"}, 32'(b_data), 32'(exp));
      end
      if (c_vo && c_lat == 0) begin
        c_lat = edges;
        check({tag, "_c_data"}, 32'(c_data), 32'(exp));
      end
    end
    check({tag, "_b_lat"}, 32'(b_lat), 32'd3);
    check({tag, "_c_lat"}, 32'(c_lat), 32'd2);
    bc_rdy_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bc_rdy_in = 1'b0;
    check({tag, "_b_rdy"}, 32'(b_rdy_out), 32'd1);
    check({tag, "_c_rdy"}, 32'(c_rdy_out), 32'd1);
  endtask

  initial begin
    int edges;
    int bad;

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy",  32'(a_rdy_out), 32'd0);
    check("rst_vo",   32'(a_vo),      32'd0);
    check("rst_data", 32'(a_data),    32'd0);
    check("rst_b_rdy", 32'(b_rdy_out), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_rdy", 32'(a_rdy_out), 32'd1);

    // ---- main function, 8-bit, two chunks
    op_a("a5_3c", 8'hA5, 8'h3C, 9'h069);
    op_a("3c_a5", 8'h3C, 8'hA5, 9'h197);
    op_a("10_01", 8'h10, 8'h01, 9'h00F);
    op_a("00_00", 8'h00, 8'h00, 9'h000);
    op_a("ff_ff", 8'hFF, 8'hFF, 9'h000);
    op_a("00_ff", 8'h00, 8'hFF, 9'h101);

    // ---- backpressure: hold in DONE, pulse new operands
    start_a(8'hA5, 8'h3C, edges);
    check("bp_lat", 32'(edges), 32'd3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      a_d1 = 8'h01; a_d2 = 8'h02; a_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (a_vo !== 1'b1 || a_data !== 9'h069 || a_rdy_out !== 1'b0) bad++;
    end
    a_valid = 1'b0;
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_data",   32'(a_data), 32'h069);
    release_a("bp");    // ready_o high means the pulsed operands were not taken
    op_a("after_bp", 8'h20, 8'h03, 9'h01D);

    // ---- reset one cycle after accept
    a_d1 = 8'h3C; a_d2 = 8'hA5; a_valid = 1'b1;
    @(posedge clk);                     // accept
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_vo",   32'(a_vo),      32'd0);
    check("mid_rst_data", 32'(a_data),    32'd0);
    check("mid_rst_rdy",  32'(a_rdy_out), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rdy_after", 32'(a_rdy_out), 32'd1);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_vo !== 1'b0 || a_rdy_out !== 1'b1) bad++;
    end
    check("mid_rst_no_result", 32'(bad), 32'd0);
    op_a("after_rst", 8'h81, 8'h7F, 9'h002);

    // ---- unequal widths, N=2 and N=1
    op_bc("3f_7", 6'h3F, 3'h7, 7'h38);
    op_bc("00_7", 6'h00, 3'h7, 7'h79);
    op_bc("05_5", 6'h05, 3'h5, 7'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
